// File: rtl/nqueen_cfu_sequencer_if.sv
// Command/response handshake between the N-Queens sequencer (master) and the CFU (slave).
// Signal names match the CFU command-port naming so the CFU side needs no renaming.
interface nqueen_cfu_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid,
        output cmd_payload_function_id,
        output cmd_payload_inputs_0,
        output cmd_payload_inputs_1,
        output rsp_ready,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid,
        input  cmd_payload_function_id,
        input  cmd_payload_inputs_0,
        input  cmd_payload_inputs_1,
        input  rsp_ready,
        output cmd_ready,
        output rsp_valid,
        output rsp_payload_outputs_0
    );
endinterface

// File: rtl/nqueen_cfu_sequencer.sv
// Autonomous N-Queens CFU master: sweeps first-row columns col_lo..col_hi, issuing
// init / kernel* / get-ret per column and accumulating the total solution count.
module nqueen_cfu_sequencer #(
    parameter int unsigned N     = 16,
    parameter int unsigned CNT_W = 48
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [4:0]             i_col_lo,
    input  logic [4:0]             i_col_hi,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic                   o_aborted,
    output logic [31:0]            o_total,
    output logic [31:0]            o_col_cnt,
    output logic [CNT_W-1:0]       o_steps,
    nqueen_cfu_sequencer_if.master cfu
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_KERN,
        S_GET,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_acc;
    logic [4:0]       r_col;
    logic [4:0]       r_col_hi;
    logic             r_done;
    logic             r_err;
    logic             r_aborted;
    logic [31:0]      r_total;
    logic [31:0]      r_col_cnt;
    logic [CNT_W-1:0] r_steps;

    logic w_active;
    logic w_cmplt;
    logic w_range_ok;
    logic w_last_col;
    logic w_accept;
    logic w_reject;

    assign w_active   = (r_state == S_INIT) || (r_state == S_KERN) || (r_state == S_GET);
    assign w_range_ok = (32'(i_col_hi) < N) && (i_col_lo <= i_col_hi);
    assign w_last_col = (r_col == r_col_hi);

    // r_acc marks an accepted command awaiting its response; a response counts
    // only when a command is accepted this cycle or already outstanding.
    assign w_cmplt = w_active && (r_acc || cfu.cmd_ready) && cfu.rsp_valid;

    assign cfu.cmd_valid               = w_active && !r_acc;
    assign cfu.rsp_ready               = w_active;
    assign cfu.cmd_payload_function_id = (r_state == S_KERN) ? 10'd1 :
                                         (r_state == S_GET)  ? 10'd2 : 10'd0;
    assign cfu.cmd_payload_inputs_0    = (r_state == S_INIT) ? {27'd0, r_col} : '0;
    assign cfu.cmd_payload_inputs_1    = '0;

    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_aborted = r_aborted;
    assign o_total   = r_total;
    assign o_col_cnt = r_col_cnt;
    assign o_steps   = r_steps;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_range_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_INIT;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_INIT: begin
                if (w_cmplt) begin
                    w_state_nxt = i_abort ? S_DONE : S_KERN;
                end
            end
            S_KERN: begin
                if (w_cmplt) begin
                    if (i_abort) begin
                        w_state_nxt = S_DONE;
                    end else if (cfu.rsp_payload_outputs_0 == 32'd0) begin
                        w_state_nxt = S_GET;
                    end
                end
            end
            S_GET: begin
                if (w_cmplt) begin
                    w_state_nxt = (i_abort || w_last_col) ? S_DONE : S_INIT;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_acc     <= 1'b0;
            r_col     <= '0;
            r_col_hi  <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_aborted <= 1'b0;
            r_total   <= '0;
            r_col_cnt <= '0;
            r_steps   <= '0;
        end else begin
            r_acc  <= w_active && !w_cmplt && (r_acc || cfu.cmd_ready);
            r_done <= w_reject || (w_state_nxt == S_DONE);

            if (w_accept) begin
                r_col     <= i_col_lo;
                r_col_hi  <= i_col_hi;
                r_total   <= '0;
                r_steps   <= '0;
                r_err     <= 1'b0;
                r_aborted <= 1'b0;
            end

            if (w_reject) begin
                r_err <= 1'b1;
            end

            if (w_cmplt && i_abort) begin
                r_aborted <= 1'b1;
            end

            if (w_cmplt && (r_state == S_KERN) && (r_steps != '1)) begin
                r_steps <= r_steps + CNT_W'(1);
            end

            // Accumulation happens even when an abort ends the run on this GET.
            if (w_cmplt && (r_state == S_GET)) begin
                r_col_cnt <= cfu.rsp_payload_outputs_0;
                r_total   <= r_total + cfu.rsp_payload_outputs_0;
                if (w_state_nxt == S_INIT) begin
                    r_col <= r_col + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nqueen_cfu_sequencer.sv
// Bench for nqueen_cfu_sequencer: a behavioural backtracking CFU with random handshake
// delays plus an event-level model of the sequencer's visible outputs, compared every cycle.
`timescale 1ns/1ps
module tb_nqueen_cfu_sequencer;
    localparam int unsigned DUT_N = 8;
    localparam int unsigned CNT_W = 48;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [4:0]       col_lo;
    logic [4:0]       col_hi;
    logic             busy;
    logic             done;
    logic             err;
    logic             aborted_o;
    logic [31:0]      total;
    logic [31:0]      col_cnt;
    logic [CNT_W-1:0] steps;

    nqueen_cfu_sequencer_if bus ();

    nqueen_cfu_sequencer #(.N(DUT_N), .CNT_W(CNT_W)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_start   (start),
        .i_abort   (abort),
        .i_col_lo  (col_lo),
        .i_col_hi  (col_hi),
        .o_busy    (busy),
        .o_done    (done),
        .o_err     (err),
        .o_aborted (aborted_o),
        .o_total   (total),
        .o_col_cnt (col_cnt),
        .o_steps   (steps),
        .cfu       (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Behavioural CFU: one backtracking move per kernel call
    int          cfu_n = 8;
    bit          zero_wait = 1'b1;
    int          pos[16];
    int          cur_row;
    int          sols;
    int          cur_col = -1;
    int          k_this;
    int          n_init;
    int          cr_wait;
    int          rsp_wait;
    bit          pend;
    logic [31:0] rsp_val;
    int          kind_pend;
    int          exp_kind;
    int          abort_col = -1;
    int          abort_k = 0;

    // Expected sequencer outputs
    bit               m_busy, m_done, m_err, m_ab;
    logic [31:0]      m_total, m_col_cnt;
    logic [CNT_W-1:0] m_steps;
    int               m_col, m_hi;

    int col_res[$];
    int col_k[$];
    int cyc = 0;
    int run_start_cyc, run_done_cyc;

    int exp4[4] = '{0, 1, 1, 0};
    int exp8[8] = '{4, 8, 16, 18, 18, 16, 8, 4};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_aborted"}, aborted_o, 0);
        chk({tag, "_total"}, total, 0);
        chk({tag, "_col_cnt"}, col_cnt, 0);
        chk({tag, "_steps"}, steps, 0);
        chk({tag, "_cmd_valid"}, bus.cmd_valid, 0);
        chk({tag, "_rsp_ready"}, bus.rsp_ready, 0);
        chk({tag, "_func_id"}, bus.cmd_payload_function_id, 0);
        chk({tag, "_inputs_0"}, bus.cmd_payload_inputs_0, 0);
        chk({tag, "_inputs_1"}, bus.cmd_payload_inputs_1, 0);
    endtask

    function automatic bit q_safe(input int row, input int c);
        for (int r = 0; r < row; r++) begin
            if (pos[r] == c || pos[r] - c == row - r || c - pos[r] == row - r) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic cfu_exec(input int fid, input int arg, output logic [31:0] res);
        int c;
        if (fid == 0) begin
            for (int i = 0; i < 16; i++) pos[i] = -1;
            pos[0]  = arg;
            cur_row = 1;
            sols    = 0;
            cur_col = arg;
            k_this  = 0;
            n_init++;
            res = $urandom;
        end else if (fid == 1) begin
            k_this++;
            if (cur_row <= 0) begin
                res = 0;
            end else begin
                c = pos[cur_row] + 1;
                while (c < cfu_n && !q_safe(cur_row, c)) c++;
                if (c < cfu_n) begin
                    pos[cur_row] = c;
                    if (cur_row == cfu_n - 1) sols++;
                    else begin
                        cur_row++;
                        pos[cur_row] = -1;
                    end
                end else begin
                    pos[cur_row] = -1;
                    cur_row--;
                end
                res = 1;
            end
        end else begin
            res = sols;
            col_res.push_back(sols);
            col_k.push_back(k_this);
        end
    endtask

    function automatic int exp_runlen();
        int s = 2;
        foreach (col_k[i]) s += col_k[i] + 2;
        return s;
    endfunction

    function automatic longint ksum();
        longint s = 0;
        foreach (col_k[i]) s += col_k[i];
        return s;
    endfunction

    // Compare the DUT against the model, then advance CFU + model for this cycle's inputs.
    always @(negedge clk) begin
        bit ev;
        cyc++;
        if (rst) begin
            check_zero("rst");
            m_busy = 0; m_done = 0; m_err = 0; m_ab = 0;
            m_total = 0; m_col_cnt = 0; m_steps = 0; m_col = 0; m_hi = 0;
            pend = 0; cr_wait = 0; rsp_wait = 0; exp_kind = 0; cur_col = -1; k_this = 0;
            abort = 1'b0;
            bus.cmd_ready = 1'b0;
            bus.rsp_valid = 1'b0;
            bus.rsp_payload_outputs_0 = '0;
        end else begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("aborted", aborted_o, m_ab);
            chk("total", total, m_total);
            chk("col_cnt", col_cnt, m_col_cnt);
            chk("steps", steps, m_steps);
            chk("cmd_valid", bus.cmd_valid, m_busy && !m_done && !pend);
            chk("rsp_ready", bus.rsp_ready, m_busy && !m_done);
            if (done && m_done && m_busy) run_done_cyc = cyc;
            if (bus.cmd_valid && m_busy && !m_done && !pend) begin
                chk("func_id", bus.cmd_payload_function_id, exp_kind);
                chk("inputs_0", bus.cmd_payload_inputs_0, (exp_kind == 0) ? m_col : 0);
                chk("inputs_1", bus.cmd_payload_inputs_1, 0);
            end

            ev = 1'b0;
            bus.cmd_ready = 1'b0;
            bus.rsp_valid = 1'b0;
            bus.rsp_payload_outputs_0 = $urandom;
            if (m_busy && m_done) begin
                m_busy = 0;
                m_done = 0;
                abort  = 1'b0;
            end else if (m_busy) begin
                if (pend) begin
                    if (rsp_wait == 0) begin
                        ev   = 1'b1;
                        pend = 1'b0;
                    end else rsp_wait--;
                end else if (bus.cmd_valid) begin
                    if (cr_wait == 0) begin
                        bus.cmd_ready = 1'b1;
                        kind_pend = int'(bus.cmd_payload_function_id);
                        cfu_exec(kind_pend, int'(bus.cmd_payload_inputs_0), rsp_val);
                        if (kind_pend == 1 && cur_col == abort_col && k_this == abort_k) abort = 1'b1;
                        rsp_wait = zero_wait ? 0 : int'($urandom_range(0, 3));
                        cr_wait  = zero_wait ? 0 : int'($urandom_range(0, 3));
                        if (rsp_wait == 0) ev = 1'b1;
                        else begin
                            pend = 1'b1;
                            rsp_wait--;
                        end
                    end else begin
                        cr_wait--;
                        // stray response with no command outstanding: must be ignored
                        if ($urandom_range(0, 2) == 0) begin
                            bus.rsp_valid = 1'b1;
                            bus.rsp_payload_outputs_0 = '0;
                        end
                    end
                end
                if (ev) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_payload_outputs_0 = rsp_val;
                    if (kind_pend == 0) exp_kind = 1;
                    else if (kind_pend == 1) exp_kind = (rsp_val == 0) ? 2 : 1;
                    else exp_kind = 0;
                    if (kind_pend == 1 && m_steps != '1) m_steps = m_steps + 1;
                    if (kind_pend == 2) begin
                        m_total   = m_total + rsp_val;
                        m_col_cnt = rsp_val;
                    end
                    if (abort) begin
                        m_ab   = 1;
                        m_done = 1;
                    end else if (kind_pend == 2 && m_col == m_hi) begin
                        m_done = 1;
                    end
                    if (kind_pend == 2) m_col++;
                end
            end else begin
                m_done = 0;
                if (start) begin
                    if (col_hi < DUT_N && col_lo <= col_hi) begin
                        m_busy = 1; m_total = 0; m_steps = 0; m_err = 0; m_ab = 0;
                        m_col = int'(col_lo); m_hi = int'(col_hi);
                        exp_kind = 0; pend = 0;
                        cr_wait = zero_wait ? 0 : int'($urandom_range(0, 3));
                        col_res.delete(); col_k.delete();
                        n_init = 0;
                        run_start_cyc = cyc;
                    end else begin
                        m_err  = 1;
                        m_done = 1;
                    end
                end
            end
        end
    end

    task automatic run(input int n, input int lo, input int hi, input bit zw,
                       input int a_col, input int a_k, input int rst_col, input int extra_start);
        int cnt;
        cfu_n = n; zero_wait = zw; abort_col = a_col; abort_k = a_k;
        @(posedge clk); #1;
        col_lo = 5'(lo); col_hi = 5'(hi); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        while ((m_busy || m_done) && cnt < 40000) begin
            if (cnt == extra_start) begin
                start  = 1'b1;
                col_lo = 5'd1;
                col_hi = 5'd2;
            end else start = 1'b0;
            if (rst_col >= 0 && cur_col == rst_col && exp_kind == 1 && k_this > 3) begin
                rst = 1'b1;
                #1 check_zero("midrun");
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0;
        if (cnt >= 40000) chk("run_timeout", 1, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; col_lo = '0; col_hi = '0;
        #1 rst = 1'b1;
        #1 check_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // N=4 board, zero-wait
        run(4, 0, 3, 1'b1, -1, 0, -1, -1);
        chk("n4_total", total, 2);
        chk("n4_err", err, 0);
        chk("n4_ncols", col_res.size(), 4);
        for (int i = 0; i < 4; i++) chk("n4_col", col_res[i], exp4[i]);
        chk("n4_runlen", run_done_cyc - run_start_cyc + 1, exp_runlen());

        // N=8, zero-wait, with an ignored start pulse mid-run
        run(8, 0, 7, 1'b1, -1, 0, -1, 10);
        chk("n8_total", total, 92);
        chk("n8_ncols", col_res.size(), 8);
        for (int i = 0; i < 8; i++) chk("n8_col", col_res[i], exp8[i]);
        chk("n8_steps", steps, ksum());
        chk("n8_runlen", run_done_cyc - run_start_cyc + 1, exp_runlen());

        // Rejected ranges
        run(8, 5, 2, 1'b1, -1, 0, -1, -1);
        chk("rej1_err", err, 1);
        chk("rej1_total_kept", total, 92);
        run(8, 0, 8, 1'b1, -1, 0, -1, -1);
        chk("rej2_err", err, 1);
        chk("rej2_busy", busy, 0);

        // N=8 with random handshake delays; clears err
        run(8, 0, 7, 1'b0, -1, 0, -1, -1);
        chk("dly_err_cleared", err, 0);
        chk("dly_total", total, 92);
        chk("dly_steps", steps, ksum());

        // Abort during KERN in column 3
        run(8, 0, 7, 1'b1, 3, 10, -1, -1);
        chk("abort_flag", aborted_o, 1);
        chk("abort_total", total, 28);
        chk("abort_inits", n_init, 4);
        chk("abort_ncols", col_res.size(), 3);

        // Reset during KERN in column 2, then a fresh N=4 run
        run(8, 0, 7, 1'b1, -1, 0, 2, -1);
        run(4, 0, 3, 1'b1, -1, 0, -1, -1);
        chk("post_rst_total", total, 2);
        chk("post_rst_aborted", aborted_o, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nqueen_cfu_sequencer.md
# nqueen_cfu_sequencer

Autonomous master for the N-Queens CFU command port. It sweeps a host-given range of first-row columns, issuing init, repeated kernel steps and get-ret for each column, and accumulates the solution count. It replaces the CPU software loop, so a whole count completes with one host start pulse. It sits between a CSR/host front end and the CFU, driving the CFU's cmd/rsp handshake exactly as the CPU would.

## Interface
- N, 16, board size; must equal the CFU's compiled board size
- CNT_W, 48, width of the kernel-step counter
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle run request; sampled only in IDLE
- abort  in  1  level; ends the run at the next command boundary
- col_lo  in  5  first starting column
- col_hi  in  5  last starting column, inclusive
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a run completes or is rejected
- err  out  1  set when a run is rejected; cleared by the next accepted start
- aborted  out  1  set when a run is ended by abort; cleared by the next start
- total  out  32  accumulated solution count for the current or last run
- col_cnt  out  32  get-ret value for the most recently finished column
- steps  out  CNT_W  kernel commands accepted in the current or last run
- cmd_valid  out  1  command valid to the CFU
- cmd_ready  in  1  CFU accepts the command
- cmd_payload_function_id  out  10  0 = init, 1 = kernel, 2 = get-ret
- cmd_payload_inputs_0  out  32  zero-extended current column for init; 0 otherwise
- cmd_payload_inputs_1  out  32  always 0
- rsp_valid  in  1  CFU response valid
- rsp_ready  out  1  sequencer accepts the response
- rsp_payload_outputs_0  in  32  CFU result

## Operation
- States: IDLE, INIT, KERN, GET, DONE.
- Reset values: all outputs 0; state IDLE; the internal column register is 0.
- IDLE, start = 1:
  - If col_hi ≥ N or col_lo > col_hi: err ← 1, done pulses the next cycle, state stays IDLE, and no CFU command is issued.
  - Otherwise: col ← col_lo, total ← 0, steps ← 0, err ← 0, aborted ← 0, go to INIT.
- Only one command is outstanding at a time.
  - cmd_valid and the payload are held stable until cmd_valid && cmd_ready.
  - rsp_ready = 1 in INIT, KERN and GET.
  - A command completes at the first cycle, at or after acceptance, with rsp_valid && rsp_ready. The same cycle as acceptance is legal and is the case with the combinational CFU.
  - A response with no outstanding command is ignored.
- INIT: function 0, inputs_0 = col. On completion go to KERN. The response is discarded.
- KERN: function 1. On each completion, steps += 1.
  - Response ≠ 0: stay in KERN and reissue.
  - Response = 0: go to GET.
- GET: function 2. On completion:
  - col_cnt ← response; total ← total + response (32-bit wrap).
  - If col == col_hi: go to DONE.
  - Else: col ← col + 1, go to INIT.
- DONE: done = 1 for one cycle, then IDLE.
- abort:
  - Sampled at a completion cycle in INIT, KERN or GET.
  - If high: the next state is DONE instead of the normal transition, and aborted ← 1.
  - The GET accumulation still happens if the abort lands on a GET completion.
  - cmd_valid is never withdrawn before acceptance.
- A start pulse while busy is ignored.
- steps saturates at all-ones.

## Timing
- start in cycle t → cmd_valid high from t+1.
- With a zero-wait CFU (cmd_ready = rsp_valid = 1 combinationally):
  - Each command occupies one cycle, and kernel commands run back-to-back with cmd_valid held high.
  - A column with K kernel steps costs K+2 cycles.
  - A run costs 1 + Σ(K_c+2) + 1 cycles, with done in the last of them.
- busy falls in the cycle after done.
- Reset asserted mid-run: all outputs go to reset values immediately (asynchronous). CFU state needs no cleanup because every run begins with init.

## Test plan
- N=4 behavioural CFU, col_lo=0, col_hi=3 → col_cnt sequence 0,1,1,0; total=2; done is one pulse; err=0; the function_id trace per column is 0,1…1,2.
- N=8, cols 0..7 → per-column 4,8,16,18,18,16,8,4; total=92; steps equals the model's kernel-call count.
- CFU with a random 0-3 cycle cmd_ready/rsp_valid delay, N=8 → total=92; payload stable while cmd_valid && !cmd_ready.
- col_lo=5, col_hi=2; then col_hi=N → err=1, done one cycle after start, no cmd_valid; a following valid start clears err.
- abort raised mid-KERN in column 3 of the N=8 run → no INIT is issued afterwards; aborted=1; done pulses; total=4+8+16=28.
- reset asserted during KERN → all outputs 0 within the cycle; a subsequent N=4 run gives total=2.
